// File: rtl/reg_writeback_cntrl_if.sv
// Writeback stage bus: memory-access stage fields, data-memory read response,
// and the register-file / CSR-file write ports plus pipeline status.
// slave = the writeback controller; master = upstream/driver side.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef FUNCT3_LEN
`define FUNCT3_LEN 3
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef SYS_REGS_WIDTH
`define SYS_REGS_WIDTH 5
`endif
`ifndef CSR_BASE_WIDTH
`define CSR_BASE_WIDTH 12
`endif
`ifndef CSR_UIMM_WIDTH
`define CSR_UIMM_WIDTH 5
`endif

interface reg_writeback_cntrl_if;
    logic                         halt;
    logic [`OPCODE_WIDTH-1:0]     opcode_in;
    logic [`FUNCT3_LEN-1:0]       funct3_in;
    logic [`XLEN-1:0]             rd_data_in;
    logic [`SYS_REGS_WIDTH-1:0]   rd_addr_in;
    logic [`XLEN-1:0]             csr_data_in;
    logic [`CSR_BASE_WIDTH-1:0]   csr_addr_in;
    logic [`CSR_UIMM_WIDTH-1:0]   uimm_in;
    logic [`XLEN-1:0]             mem_rdata;
    logic                         mem_rvalid;
    logic                         rf_we;
    logic [`SYS_REGS_WIDTH-1:0]   rf_waddr;
    logic [`XLEN-1:0]             rf_wdata;
    logic                         csr_we;
    logic [`CSR_BASE_WIDTH-1:0]   csr_waddr;
    logic [`XLEN-1:0]             csr_wdata;
    logic                         stall_out;
    logic                         load_fault;

    modport slave (
        input  halt, opcode_in, funct3_in, rd_data_in, rd_addr_in,
               csr_data_in, csr_addr_in, uimm_in, mem_rdata, mem_rvalid,
        output rf_we, rf_waddr, rf_wdata, csr_we, csr_waddr, csr_wdata,
               stall_out, load_fault
    );

    modport master (
        output halt, opcode_in, funct3_in, rd_data_in, rd_addr_in,
               csr_data_in, csr_addr_in, uimm_in, mem_rdata, mem_rvalid,
        input  rf_we, rf_waddr, rf_wdata, csr_we, csr_waddr, csr_wdata,
               stall_out, load_fault
    );
endinterface

// File: rtl/reg_writeback_cntrl.sv
// Purpose: final pipeline stage; drives register-file and CSR-file writes, waits for load data.
// Latency: non-load writes appear one cycle after capture; loads write one cycle after mem_rvalid.
// Backpressure: stall_out (registered) is high while waiting; upstream holds inputs, which are ignored.
// Ports: clk, rst_n (async active-low), wb (reg_writeback_cntrl_if.slave: stage fields in,
//        rf/csr write ports, stall_out and load_fault out).
// Optional feature: define CSR_WB_EN to build the CSR write path; otherwise csr_* outputs are 0.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef FUNCT3_LEN
`define FUNCT3_LEN 3
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef SYS_REGS_WIDTH
`define SYS_REGS_WIDTH 5
`endif
`ifndef CSR_BASE_WIDTH
`define CSR_BASE_WIDTH 12
`endif
`ifndef CSR_UIMM_WIDTH
`define CSR_UIMM_WIDTH 5
`endif

module reg_writeback_cntrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg_writeback_cntrl_if.slave  wb
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {ST_IDLE, ST_WAIT} state_t;

    state_t                       state, state_nxt;
    logic [7:0]                   cnt, cnt_nxt;
    logic [`SYS_REGS_WIDTH-1:0]   ld_rd, ld_rd_nxt;
    logic [2:0]                   ld_f3, ld_f3_nxt;
    logic [1:0]                   ld_off, ld_off_nxt;

    logic                         rf_we_q, rf_we_nxt;
    logic [`SYS_REGS_WIDTH-1:0]   rf_waddr_q, rf_waddr_nxt;
    logic [`XLEN-1:0]             rf_wdata_q, rf_wdata_nxt;
    logic                         csr_we_nxt;
    logic [`CSR_BASE_WIDTH-1:0]   csr_waddr_nxt;
    logic [`XLEN-1:0]             csr_wdata_nxt;
    logic                         stall_q, stall_nxt;
    logic                         fault_q, fault_nxt;
    logic                         wr_ok;
    logic [7:0]                   ld_byte;
    logic [15:0]                  ld_half;

`ifdef CSR_WB_EN
    logic                         csr_we_q;
    logic [`CSR_BASE_WIDTH-1:0]   csr_waddr_q;
    logic [`XLEN-1:0]             csr_wdata_q;
    logic [`XLEN-1:0]             csr_src;
`endif

    // Lane selection on the word returned by memory; halfword ignores addr[0].
    assign ld_byte = wb.mem_rdata[{ld_off, 3'b000} +: 8];
    assign ld_half = ld_off[1] ? wb.mem_rdata[31:16] : wb.mem_rdata[15:0];

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        ld_rd_nxt     = ld_rd;
        ld_f3_nxt     = ld_f3;
        ld_off_nxt    = ld_off;
        rf_waddr_nxt  = rf_waddr_q;
        rf_wdata_nxt  = rf_wdata_q;
        fault_nxt     = 1'b0;
        wr_ok         = 1'b0;
        csr_we_nxt    = 1'b0;
        csr_waddr_nxt = '0;
        csr_wdata_nxt = '0;
`ifdef CSR_WB_EN
        csr_waddr_nxt = csr_waddr_q;
        csr_wdata_nxt = csr_wdata_q;
        csr_src       = '0;
`endif
        case (state)
            ST_IDLE: begin
                if (!wb.halt) begin
                    case (wb.opcode_in)
                        OP_LOAD: begin
                            ld_rd_nxt  = wb.rd_addr_in;
                            ld_f3_nxt  = wb.funct3_in;
                            ld_off_nxt = wb.rd_data_in[1:0];
                            cnt_nxt    = '0;
                            state_nxt  = ST_WAIT;
                        end
                        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OP, OP_OPIMM: begin
                            rf_waddr_nxt = wb.rd_addr_in;
                            rf_wdata_nxt = wb.rd_data_in;
                            wr_ok        = 1'b1;
                        end
                        OP_SYSTEM: begin
                            // funct3 x00 is not a CSR op (ECALL/EBREAK or reserved).
                            if (wb.funct3_in[1:0] != 2'b00) begin
                                rf_waddr_nxt = wb.rd_addr_in;
                                rf_wdata_nxt = wb.csr_data_in;
                                wr_ok        = 1'b1;
`ifdef CSR_WB_EN
                                csr_src = wb.funct3_in[2]
                                        ? {{(`XLEN-`CSR_UIMM_WIDTH){1'b0}}, wb.uimm_in}
                                        : wb.rd_data_in;
                                case (wb.funct3_in[1:0])
                                    2'b01:   csr_wdata_nxt = csr_src;
                                    2'b10:   csr_wdata_nxt = wb.csr_data_in | csr_src;
                                    default: csr_wdata_nxt = wb.csr_data_in & ~csr_src;
                                endcase
                                csr_waddr_nxt = wb.csr_addr_in;
                                // CSRRSI/CSRRCI with zero immediate are pure reads.
                                csr_we_nxt = !(wb.funct3_in[2] && wb.funct3_in[1] &&
                                               (wb.uimm_in == '0));
`endif
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_WAIT: begin
                if (wb.mem_rvalid) begin
                    // Data in the last allowed cycle beats the timeout.
                    state_nxt    = ST_IDLE;
                    rf_waddr_nxt = ld_rd;
                    wr_ok        = 1'b1;
                    case (ld_f3)
                        3'b000:  rf_wdata_nxt = {{24{ld_byte[7]}}, ld_byte};
                        3'b100:  rf_wdata_nxt = {24'd0, ld_byte};
                        3'b001:  rf_wdata_nxt = {{16{ld_half[15]}}, ld_half};
                        3'b101:  rf_wdata_nxt = {16'd0, ld_half};
                        3'b010:  rf_wdata_nxt = wb.mem_rdata;
                        default: wr_ok = 1'b0;
                    endcase
                end else if (cnt == CNT_LAST) begin
                    fault_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        rf_we_nxt = wr_ok && (rf_waddr_nxt != '0);
        stall_nxt = (state_nxt == ST_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            ld_rd      <= '0;
            ld_f3      <= '0;
            ld_off     <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            stall_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ld_rd      <= ld_rd_nxt;
            ld_f3      <= ld_f3_nxt;
            ld_off     <= ld_off_nxt;
            rf_we_q    <= rf_we_nxt;
            rf_waddr_q <= rf_waddr_nxt;
            rf_wdata_q <= rf_wdata_nxt;
            stall_q    <= stall_nxt;
            fault_q    <= fault_nxt;
        end
    end

`ifdef CSR_WB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_we_q    <= 1'b0;
            csr_waddr_q <= '0;
            csr_wdata_q <= '0;
        end else begin
            csr_we_q    <= csr_we_nxt;
            csr_waddr_q <= csr_waddr_nxt;
            csr_wdata_q <= csr_wdata_nxt;
        end
    end

    assign wb.csr_we    = csr_we_q;
    assign wb.csr_waddr = csr_waddr_q;
    assign wb.csr_wdata = csr_wdata_q;
`else
    logic unused_csr;
    assign unused_csr   = ^{wb.csr_addr_in, wb.uimm_in, csr_we_nxt, csr_waddr_nxt, csr_wdata_nxt};
    assign wb.csr_we    = 1'b0;
    assign wb.csr_waddr = '0;
    assign wb.csr_wdata = '0;
`endif

    assign wb.rf_we      = rf_we_q;
    assign wb.rf_waddr   = rf_waddr_q;
    assign wb.rf_wdata   = rf_wdata_q;
    assign wb.stall_out  = stall_q;
    assign wb.load_fault = fault_q;
endmodule

// File: tb/tb_reg_writeback_cntrl.sv
module tb_reg_writeback_cntrl;
    localparam int TO = 16;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_writeback_cntrl_if bus();

    reg_writeback_cntrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [4:0] rd, input logic [31:0] old, input logic [11:0] ca,
                         input logic [4:0] u);
        bus.opcode_in   = op;
        bus.funct3_in   = f3;
        bus.rd_data_in  = a;
        bus.rd_addr_in  = rd;
        bus.csr_data_in = old;
        bus.csr_addr_in = ca;
        bus.uimm_in     = u;
    endtask

    // STORE never writes anything, so it is a safe idle filler.
    task automatic filler();
        drive(OP_STORE, 3'($urandom), $urandom, 5'($urandom), $urandom, 12'($urandom), 5'($urandom));
        bus.halt       = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
    endtask

    function automatic bit is_alu(input logic [6:0] op);
        return op == OP_LUI || op == OP_AUIPC || op == OP_JAL || op == OP_JALR ||
               op == OP_OP || op == OP_OPIMM;
    endfunction

    // Expected load result from the architectural rules, using plain arithmetic.
    function automatic logic [31:0] ld_ref(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w, output bit ok);
        logic [31:0] b, h;
        b  = (w >> (8 * off)) & 32'hFF;
        h  = (w >> (16 * (off / 2))) & 32'hFFFF;
        ok = 1'b1;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            3'd2:    return w;
            default: begin ok = 1'b0; return 32'd0; end
        endcase
    endfunction

    // Non-load instruction (or anything under halt). Called at a negedge.
    task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [4:0] rd, input logic [31:0] old, input logic [11:0] ca,
                         input logic [4:0] u, input bit h);
        bit upd, cupd;
        logic [31:0] wd, cw, src;
        upd = 1'b0; cupd = 1'b0; wd = '0; cw = '0; src = '0;
        drive(op, f3, a, rd, old, ca, u);
        bus.halt       = h;
        bus.mem_rvalid = 1'($urandom);
        bus.mem_rdata  = $urandom;
        if (!h) begin
            if (is_alu(op)) begin
                upd = 1'b1; wd = a;
            end else if (op == OP_SYSTEM && f3 != 3'd0 && f3 != 3'd4) begin
                upd = 1'b1; wd = old;
`ifdef CSR_WB_EN
                src = (f3 >= 3'd4) ? {27'd0, u} : a;
                if (f3 == 3'd1 || f3 == 3'd5)      cw = src;
                else if (f3 == 3'd2 || f3 == 3'd6) cw = old | src;
                else                               cw = old & ~src;
                cupd = !((f3 == 3'd6 || f3 == 3'd7) && u == 5'd0);
`endif
            end
        end
        @(negedge clk);
        chk("rf_we", bus.rf_we, upd && rd != 5'd0);
        if (upd) begin
            chk("rf_waddr", bus.rf_waddr, rd);
            chk("rf_wdata", bus.rf_wdata, wd);
        end
        chk("csr_we", bus.csr_we, cupd);
        if (cupd) begin
            chk("csr_waddr", bus.csr_waddr, ca);
            chk("csr_wdata", bus.csr_wdata, cw);
        end
`ifndef CSR_WB_EN
        chk("csr_wdata_tied", bus.csr_wdata, 32'd0);
`endif
        chk("stall_nl", bus.stall_out, 1'b0);
        chk("fault_nl", bus.load_fault, 1'b0);
        filler();
    endtask

    // Load whose data arrives in WAIT cycle d (d=0: never). Called at a negedge.
    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                           input int d, input logic [31:0] word);
        int n;
        bit got, ok;
        logic [31:0] ev;
        got = (d >= 1 && d <= TO);
        n   = got ? d : TO;
        ev  = ld_ref(f3, addr[1:0], word, ok);
        drive(OP_LOAD, f3, addr, rd, $urandom, 12'($urandom), 5'($urandom));
        bus.halt       = 1'b0;
        bus.mem_rvalid = 1'($urandom);
        bus.mem_rdata  = $urandom;
        for (int w = 1; w <= n; w++) begin
            @(negedge clk);
            chk("ld_stall", bus.stall_out, 1'b1);
            chk("ld_busy_we", bus.rf_we, 1'b0);
            chk("ld_busy_fault", bus.load_fault, 1'b0);
            // Garbage upstream traffic while stalled must be ignored.
            drive(OP_OPIMM, 3'($urandom), $urandom, 5'($urandom_range(1, 31)), $urandom,
                  12'($urandom), 5'($urandom));
            bus.halt       = 1'($urandom);
            bus.mem_rvalid = (w == d);
            bus.mem_rdata  = (w == d) ? word : $urandom;
        end
        @(negedge clk);
        chk("ld_stall_end", bus.stall_out, 1'b0);
        chk("ld_rf_we", bus.rf_we, got && ok && rd != 5'd0);
        if (got && ok) begin
            chk("ld_waddr", bus.rf_waddr, rd);
            chk("ld_wdata", bus.rf_wdata, ev);
        end
        chk("ld_fault", bus.load_fault, !got);
        filler();
        for (int k = 0; k < 2 * TO && bus.stall_out === 1'b1; k++) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rf_we"}, bus.rf_we, 1'b0);
        chk({tag, "_rf_waddr"}, bus.rf_waddr, 5'd0);
        chk({tag, "_rf_wdata"}, bus.rf_wdata, 32'd0);
        chk({tag, "_csr_we"}, bus.csr_we, 1'b0);
        chk({tag, "_csr_waddr"}, bus.csr_waddr, 12'd0);
        chk({tag, "_csr_wdata"}, bus.csr_wdata, 32'd0);
        chk({tag, "_stall"}, bus.stall_out, 1'b0);
        chk({tag, "_fault"}, bus.load_fault, 1'b0);
    endtask

    logic [6:0] ops [10] = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC,
                             OP_JAL, OP_JALR, OP_OP, OP_OPIMM, OP_SYSTEM};

    initial begin
        filler();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // ADDI 0xAB -> x5
        do_op(OP_OPIMM, 3'd0, 32'h0000_00AB, 5'd5, 32'd0, 12'd0, 5'd0, 1'b0);
        // LB / LBU at offset 2 with data after 3 WAIT cycles
        do_load(3'd0, 32'h0000_1002, 5'd7, 3, 32'h1280_3456);
        do_load(3'd4, 32'h0000_1002, 5'd7, 3, 32'h1280_3456);
        // LH at offset 3 uses the upper halfword
        do_load(3'd1, 32'h0000_2003, 5'd9, 1, 32'h8001_7FFF);
        // LW that never returns, then a normal ADDI
        do_load(3'd2, 32'h0000_3000, 5'd4, 0, 32'd0);
        do_op(OP_OPIMM, 3'd0, 32'h0000_1234, 5'd6, 32'd0, 12'd0, 5'd0, 1'b0);
        // Data arriving in the last allowed cycle wins over timeout
        do_load(3'd2, 32'h0000_3000, 5'd8, TO, 32'hDEAD_BEEF);
        // CSRRS and CSRRCI with zero immediate
        do_op(OP_SYSTEM, 3'd2, 32'h0000_00F0, 5'd3, 32'h0000_000F, 12'h300, 5'd0, 1'b0);
        do_op(OP_SYSTEM, 3'd7, 32'h0000_00F0, 5'd3, 32'h0000_000F, 12'h300, 5'd0, 1'b0);
        do_op(OP_SYSTEM, 3'd5, 32'h0, 5'd2, 32'h0000_1111, 12'h341, 5'd17, 1'b0);
        // x0 destination and halt
        do_op(OP_OPIMM, 3'd0, 32'h0000_0055, 5'd0, 32'd0, 12'd0, 5'd0, 1'b0);
        do_op(OP_OPIMM, 3'd0, 32'h0000_0066, 5'd5, 32'd0, 12'd0, 5'd0, 1'b1);

        // Reset in the middle of a load wait
        drive(OP_LOAD, 3'd2, 32'h0000_4000, 5'd10, 32'd0, 12'd0, 5'd0);
        repeat (2) @(negedge clk);
        filler();
        rst_n = 1'b0;
        #1;
        chk_all_zero("midwait_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < TO + 2; k++) begin
            bus.mem_rvalid = 1'b1;
            @(negedge clk);
            chk("post_rst_we", bus.rf_we, 1'b0);
            chk("post_rst_fault", bus.load_fault, 1'b0);
        end
        filler();
        do_op(OP_OP, 3'd0, 32'hCAFE_0001, 5'd12, 32'd0, 12'd0, 5'd0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            logic [6:0] op;
            logic [4:0] rd;
            bit h;
            int r, d;
            op = ops[$urandom_range(0, 9)];
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            h  = ($urandom_range(0, 9) == 0);
            if (op == OP_LOAD && !h) begin
                r = $urandom_range(0, 9);
                if (r == 0)      d = 0;
                else if (r == 1) d = TO;
                else             d = $urandom_range(1, 8);
                do_load(3'($urandom), $urandom, rd, d, $urandom);
            end else begin
                do_op(op, 3'($urandom), $urandom, rd, $urandom, 12'($urandom),
                      ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), h);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reg_writeback_cntrl.md
# reg_writeback_cntrl

Final pipeline stage, directly downstream of the memory-access stage. Consumes that stage's registered opcode, funct3, rd and CSR fields together with the data-memory read response. Produces the register-file write port and the CSR-file write port. Loads are held in a wait state until memory returns data, then the selected lane is extracted and sign- or zero-extended. A stall and a load-fault flag go back to the pipeline control.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum WAIT cycles before a load is abandoned (range 2..255).

Ports. Reset is **asynchronous, active-low** (`rst_n`), on a single clock (`clk`).
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- halt  in  1  freezes capture of new instructions
- opcode_in  in  `OPCODE_WIDTH`  opcode from memory-access stage
- funct3_in  in  `FUNCT3_LEN`  funct3 from memory-access stage
- rd_data_in  in  `XLEN`  ALU result; effective address for LOAD; rs1 value for CSR ops
- rd_addr_in  in  `SYS_REGS_WIDTH`  destination register
- csr_data_in  in  `XLEN`  old CSR value
- csr_addr_in  in  `CSR_BASE_WIDTH`  CSR address
- uimm_in  in  `CSR_UIMM_WIDTH`  CSR immediate
- mem_rdata  in  `XLEN`  data-memory read word
- mem_rvalid  in  1  mem_rdata valid this cycle
- rf_we  out  1  register-file write enable (one-cycle pulse)
- rf_waddr  out  `SYS_REGS_WIDTH`  register-file write address
- rf_wdata  out  `XLEN`  register-file write data
- csr_we  out  1  CSR write enable (one-cycle pulse)
- csr_waddr  out  `CSR_BASE_WIDTH`  CSR write address
- csr_wdata  out  `XLEN`  CSR write data
- stall_out  out  1  high while in WAIT
- load_fault  out  1  one-cycle pulse on load timeout

## Operation
- FSM has two states, IDLE and WAIT. Reset puts it in IDLE with a timeout counter of 0, and all outputs 0.
- IDLE, halt=1: nothing is captured, and rf_we=csr_we=0 on the next edge.
- IDLE, LOAD (7'b0000011): the block latches rd_addr, funct3 and addr[1:0] from rd_data_in, then goes to WAIT. A mem_rvalid in the capture cycle is ignored.
- IDLE, STORE or BRANCH: no write.
- IDLE, LUI, AUIPC, JAL, JALR, OP or OP-IMM: on the next edge the block issues rf_we, with rf_wdata=rd_data_in.
- IDLE, SYSTEM with a CSR funct3:
  - rf_wdata=csr_data_in.
  - New CSR value for funct3 001/101 (RW/RWI): src.
  - For 010/110 (RS/RSI): old | src.
  - For 011/111 (RC/RCI): old & ~src.
  - src is rd_data_in for register forms, or uimm_in zero-extended for immediate forms.
  - Immediate RS/RC with uimm_in==0 suppresses csr_we.
- WAIT: inputs are ignored and stall_out=1. The counter increments each cycle without mem_rvalid.
- WAIT, mem_rvalid=1: lane extraction, then rf_we on the next edge, then return to IDLE.
  - LB/LBU (000/100): byte at addr[1:0].
  - LH/LHU (001/101): halfword at addr[1], where addr[0] is ignored.
  - LW (010): full word.
  - Unsigned forms zero-extend; signed forms sign-extend.
- WAIT, counter reaches TIMEOUT_CYCLES-1 without mem_rvalid: load_fault pulses, there is no write, and the FSM returns to IDLE. If mem_rvalid arrives in that same cycle, the data wins and there is no fault.
- rd_addr==0: rf_we is always suppressed. rf_waddr and rf_wdata still update.
- Unknown funct3 on LOAD or SYSTEM: no write. A load still completes its handshake.

## Timing
- Every output is a flop, reset to 0.
- Non-load latency: input in cycle N gives rf_we/csr_we high during cycle N+1, for exactly one cycle.
- Load: captured in cycle N, so stall_out is high from N+1. With mem_rvalid in cycle M>N, rf_we is high in M+1 and stall_out is low in M+1.
- stall_out is registered. Upstream must hold inputs whenever stall_out=1; the block ignores any inputs that are not held.
- Async reset mid-WAIT: the FSM is immediately in IDLE and all outputs are 0. No write and no fault are issued after release.
- load_fault and rf_we are never high in the same cycle.

## Configuration
- `CSR_WB_EN` defined: the CSR path exists as described.
- `CSR_WB_EN` undefined: the CSR logic is not compiled in.
  - csr_we, csr_waddr and csr_wdata are tied to 0.
  - SYSTEM opcodes still write csr_data_in to rd, so CSR reads are preserved.

## Test plan
- ADDI result 0x0000_00AB to rd=5: rf_we=1 one cycle later, rf_waddr=5, rf_wdata=0xAB; no stall.
- LB, addr[1:0]=2, mem_rdata=0x1280_3456 after 3 WAIT cycles: stall_out high for 3 cycles, then rf_wdata=0xFFFF_FF80. The same case with LBU gives 0x0000_0080.
- LW with mem_rvalid never asserted, TIMEOUT_CYCLES=16: load_fault pulses once after 16 stall cycles, with no rf_we; the next ADDI writes normally.
- CSRRS, old=0x0F, rs1=0xF0, rd=3: rf_wdata=0x0F and csr_wdata=0xFF. CSRRCI with uimm=0 gives csr_we=0. With `CSR_WB_EN` undefined, csr_we stays 0 and rd is still written.
- Writes to x0, halt=1 during an ADDI, and rst_n deasserted mid-WAIT: no rf_we in any case; after reset, all outputs are 0 and the FSM is in IDLE.
